// File: rtl/intra_encoder.sv
// Frame-level intra-encode scan sequencer: a luma 4x4-block raster engine and two
// independent chroma 8x8-block raster engines, each with a sticky done flag.
module intra_encoder #(
   parameter int unsigned WIDTH  = 1280,
   parameter int unsigned LENGTH = 720
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic done_luma4x4,
   output logic done_chromab8x8,
   output logic done_chromar8x8
);

   localparam int unsigned LBxN = WIDTH / 4;
   localparam int unsigned LByN = LENGTH / 4;
   localparam int unsigned CBxN = WIDTH / 16;
   localparam int unsigned CByN = LENGTH / 16;

   // Single-block dimensions still need a 1-bit counter.
   localparam int unsigned LBxW = (LBxN > 1) ? $clog2(LBxN) : 1;
   localparam int unsigned LByW = (LByN > 1) ? $clog2(LByN) : 1;
   localparam int unsigned CBxW = (CBxN > 1) ? $clog2(CBxN) : 1;
   localparam int unsigned CByW = (CByN > 1) ? $clog2(CByN) : 1;

   localparam logic [LBxW-1:0] LBxLast = LBxW'(LBxN - 1);
   localparam logic [LByW-1:0] LByLast = LByW'(LByN - 1);
   localparam logic [CBxW-1:0] CBxLast = CBxW'(CBxN - 1);
   localparam logic [CByW-1:0] CByLast = CByW'(CByN - 1);

   // Luma engine state
   logic [1:0]      lpx_q, lpx_d;
   logic [1:0]      lpy_q, lpy_d;
   logic [LBxW-1:0] lbx_q, lbx_d;
   logic [LByW-1:0] lby_q, lby_d;
   logic            ldone_q, ldone_d;

   // Chroma engine state: index 0 is Cb, index 1 is Cr
   logic [2:0]      cpx_q [2];
   logic [2:0]      cpx_d [2];
   logic [2:0]      cpy_q [2];
   logic [2:0]      cpy_d [2];
   logic [CBxW-1:0] cbx_q [2];
   logic [CBxW-1:0] cbx_d [2];
   logic [CByW-1:0] cby_q [2];
   logic [CByW-1:0] cby_d [2];
   logic            cdone_q [2];
   logic            cdone_d [2];

   logic luma_last;

   assign luma_last = (lpx_q == 2'd3) && (lpy_q == 2'd3) &&
                      (lbx_q == LBxLast) && (lby_q == LByLast);

   always_comb begin
      lpx_d   = lpx_q;
      lpy_d   = lpy_q;
      lbx_d   = lbx_q;
      lby_d   = lby_q;
      ldone_d = ldone_q;
      if (enable && !ldone_q) begin
         // Consuming the final position sets done; counters stay parked there.
         if (luma_last) begin
            ldone_d = 1'b1;
         end else begin
            lpx_d = lpx_q + 2'd1;
            if (lpx_q == 2'd3) begin
               lpy_d = lpy_q + 2'd1;
               if (lpy_q == 2'd3) begin
                  if (lbx_q == LBxLast) begin
                     lbx_d = '0;
                     lby_d = lby_q + 1'b1;
                  end else begin
                     lbx_d = lbx_q + 1'b1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         cpx_d[i]   = cpx_q[i];
         cpy_d[i]   = cpy_q[i];
         cbx_d[i]   = cbx_q[i];
         cby_d[i]   = cby_q[i];
         cdone_d[i] = cdone_q[i];
         if (enable && !cdone_q[i]) begin
            if ((cpx_q[i] == 3'd7) && (cpy_q[i] == 3'd7) &&
                (cbx_q[i] == CBxLast) && (cby_q[i] == CByLast)) begin
               cdone_d[i] = 1'b1;
            end else begin
               cpx_d[i] = cpx_q[i] + 3'd1;
               if (cpx_q[i] == 3'd7) begin
                  cpy_d[i] = cpy_q[i] + 3'd1;
                  if (cpy_q[i] == 3'd7) begin
                     if (cbx_q[i] == CBxLast) begin
                        cbx_d[i] = '0;
                        cby_d[i] = cby_q[i] + 1'b1;
                     end else begin
                        cbx_d[i] = cbx_q[i] + 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         lpx_q   <= '0;
         lpy_q   <= '0;
         lbx_q   <= '0;
         lby_q   <= '0;
         ldone_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            cpx_q[i]   <= '0;
            cpy_q[i]   <= '0;
            cbx_q[i]   <= '0;
            cby_q[i]   <= '0;
            cdone_q[i] <= 1'b0;
         end
      end else begin
         lpx_q   <= lpx_d;
         lpy_q   <= lpy_d;
         lbx_q   <= lbx_d;
         lby_q   <= lby_d;
         ldone_q <= ldone_d;
         for (int i = 0; i < 2; i++) begin
            cpx_q[i]   <= cpx_d[i];
            cpy_q[i]   <= cpy_d[i];
            cbx_q[i]   <= cbx_d[i];
            cby_q[i]   <= cby_d[i];
            cdone_q[i] <= cdone_d[i];
         end
      end
   end

   assign done_luma4x4    = ldone_q;
   assign done_chromab8x8 = cdone_q[0];
   assign done_chromar8x8 = cdone_q[1];

endmodule

// File: tb/tb_intra_encoder.sv
// Bench for intra_encoder: two frame sizes share one stimulus; an enabled-edge count model
// predicts every done flag each cycle, and literal checks pin the key thresholds.
module tb_intra_encoder;

   localparam int unsigned AW = 16;
   localparam int unsigned AL = 16;
   localparam int unsigned BW = 48;
   localparam int unsigned BL = 32;

   logic clk;
   logic reset;
   logic enable;
   logic a_l, a_b, a_r;
   logic b_l, b_b, b_r;

   int checks;
   int failures;
   bit chk_en;
   int unsigned edges;

   intra_encoder #(.WIDTH(AW), .LENGTH(AL)) u_dut_a (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .done_luma4x4    (a_l),
      .done_chromab8x8 (a_b),
      .done_chromar8x8 (a_r)
   );

   intra_encoder #(.WIDTH(BW), .LENGTH(BL)) u_dut_b (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .done_luma4x4    (b_l),
      .done_chromab8x8 (b_b),
      .done_chromar8x8 (b_r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a plane is done once it has seen pixel-count enabled edges since reset release.
   always @(posedge clk) begin
      if (!reset) edges <= 0;
      else if (enable) edges <= edges + 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_luma",  a_l, edges >= AW * AL);
         chk("a_cb",    a_b, edges >= AW * AL / 4);
         chk("a_cr",    a_r, edges >= AW * AL / 4);
         chk("b_luma",  b_l, edges >= BW * BL);
         chk("b_cb",    b_b, edges >= BW * BL / 4);
         chk("b_cr",    b_r, edges >= BW * BL / 4);
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      chk_en   = 1'b0;
      edges    = 0;
      reset    = 1'b0;
      enable   = 1'b1;

      // Continuous enable from reset release
      run(1);
      chk_en = 1'b1;
      run(2);
      chk("rst_a_luma", a_l, 1'b0);
      chk("rst_b_cb",   b_b, 1'b0);
      reset = 1'b1;
      run(63);
      chk("lit_a_cb_63", a_b, 1'b0);
      run(1);
      chk("lit_a_cb_64", a_b, 1'b1);
      chk("lit_a_cr_64", a_r, 1'b1);
      chk("lit_a_luma_64", a_l, 1'b0);
      run(191);
      chk("lit_a_luma_255", a_l, 1'b0);
      run(1);
      chk("lit_a_luma_256", a_l, 1'b1);
      run(127);
      chk("lit_b_cb_383", b_b, 1'b0);
      run(1);
      chk("lit_b_cb_384", b_b, 1'b1);
      chk("lit_b_cr_384", b_r, 1'b1);
      run(1151);
      chk("lit_b_luma_1535", b_l, 1'b0);
      run(1);
      chk("lit_b_luma_1536", b_l, 1'b1);

      // Flags stay set after done, then a single reset edge clears them
      run(100);
      chk("hold_a_luma", a_l, 1'b1);
      chk("hold_a_cb",   a_b, 1'b1);
      chk("hold_b_luma", b_l, 1'b1);
      reset = 1'b0;
      run(1);
      chk("clr_a_luma", a_l, 1'b0);
      chk("clr_a_cr",   a_r, 1'b0);
      chk("clr_b_luma", b_l, 1'b0);

      // Reset held with enable high never advances
      run(300);
      chk("held_a_luma", a_l, 1'b0);
      chk("held_a_cb",   a_b, 1'b0);

      // Enable toggles every cycle, starting low
      reset = 1'b1;
      for (int c = 1; c <= 512; c++) begin
         enable = (c % 2 == 0);
         run(1);
         if (c == 127) chk("tog_a_cb_127", a_b, 1'b0);
         if (c == 128) chk("tog_a_cb_128", a_b, 1'b1);
         if (c == 511) chk("tog_a_luma_511", a_l, 1'b0);
         if (c == 512) chk("tog_a_luma_512", a_l, 1'b1);
      end

      // Reset at enabled edge 100 restarts the full scan
      reset  = 1'b0;
      enable = 1'b1;
      run(1);
      reset = 1'b1;
      run(100);
      reset = 1'b0;
      run(1);
      reset = 1'b1;
      run(63);
      chk("rs_a_cb_63", a_b, 1'b0);
      run(1);
      chk("rs_a_cb_64", a_b, 1'b1);
      run(191);
      chk("rs_a_luma_255", a_l, 1'b0);
      run(1);
      chk("rs_a_luma_256", a_l, 1'b1);

      // Random enable with rare reset pulses
      for (int c = 0; c < 6000; c++) begin
         reset  = ($urandom_range(0, 2499) != 0);
         enable = ($urandom_range(0, 3) != 0);
         run(1);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/intra_encoder.md
Name: intra_encoder

Overview:
- Frame-level intra-encode sequencer for a 4:2:0 WIDTH x LENGTH frame.
- Three independent engines run concurrently:
  - Luma (Y) walks the frame in 4x4 blocks.
  - Chroma-blue (Cb) and chroma-red (Cr) each walk a WIDTH/2 x LENGTH/2 plane in 8x8 blocks.
- Each engine consumes one pixel position per enabled cycle and raises a sticky per-plane done flag when its plane is fully scanned.
- Sits at the top of the intra path; downstream prediction/transform stages key off the scan position and done flags.

Parameters:
- WIDTH, 1280, luma frame width in pixels; must be a multiple of 16.
- LENGTH, 720, luma frame height in lines; must be a multiple of 16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = in reset).
- enable  input  1  global advance; when 0 all engines hold state.
- done_luma4x4  output  1  sticky high once all luma 4x4 blocks are scanned.
- done_chromab8x8  output  1  sticky high once all Cb 8x8 blocks are scanned.
- done_chromar8x8  output  1  sticky high once all Cr 8x8 blocks are scanned.

Behaviour:
- One clock; reset is synchronous and active-low. Sampled at the rising edge of clk; reset==0 has priority over everything.
- Reset values:
  - All done outputs 0.
  - All scan counters 0: block column, block row, pixel row-in-block, pixel column-in-block.
- Luma engine counters:
  - px, py: 0..3 each.
  - bx: 0..WIDTH/4-1.
  - by: 0..LENGTH/4-1.
- Luma scan order per enabled cycle:
  - px increments; px wraps 3->0 and increments py.
  - py wraps 3->0 and increments bx.
  - bx wraps to 0 and increments by.
  - Blocks are raster order; pixels within a block are raster order.
- Internal luma pixel address = (by*4+py)*WIDTH + bx*4+px, range 0..WIDTH*LENGTH-1.
- Chroma engines (Cb, Cr, identical, independent counters):
  - Pixel counters 0..7 each.
  - Block counters 0..WIDTH/16-1 (columns) and 0..LENGTH/16-1 (rows).
  - Same nesting order as luma.
  - Address = (by*8+py)*(WIDTH/2) + bx*8+px.
- Completion:
  - An engine's done flag is set at the rising edge where it consumes its final position. All counters at their maximum and enable==1.
  - The flag is visible the cycle after that edge.
  - Luma done after exactly WIDTH*LENGTH enabled edges following reset release.
  - Cb and Cr done after exactly WIDTH*LENGTH/4 enabled edges; Cb and Cr assert on the same edge.
- After done: that engine's counters freeze at their final value (no wrap, no restart). The done flag stays 1 until reset.
- enable==0: no counter or flag changes in any engine. Enabled-edge counts resume exactly where they left off.
- Reset asserted mid-scan or after done: next edge returns everything to reset values. The scan restarts from position 0 once reset==1.
- Engines never interact; chroma done does not stop luma.

Test Plan:
1. WIDTH=16, LENGTH=16; reset=0 for 3 cycles, then reset=1, enable=1 continuously:
   - done_chromab8x8 and done_chromar8x8 rise together after exactly 64 enabled edges.
   - done_luma4x4 rises after exactly 256; all 0 before.
2. Same config, reset held 0 with enable=1 for 300 cycles -> all done outputs remain 0.
3. Same config; enable toggles 1/0 every cycle after reset release:
   - Chroma done after 128 cycles.
   - Luma done after 512 cycles (64 and 256 enabled edges).
4. Run to all-done, continue 100 enabled cycles -> all flags stay 1. Then reset=0 for one edge -> all flags 0 next cycle.
5. Assert reset=0 for one edge at enabled edge 100, then release -> chroma done 64 and luma done 256 enabled edges after release (full restart).
6. Default WIDTH=1280, LENGTH=720, continuous enable -> chroma done at edge 230400, luma done at edge 921600.
